// File: rtl/cpu_oci_dct_pkg.sv
// Shared types and constants for the OCI direct-conditional-trace unpacker.
// Symbols are 2-bit branch outcomes; reserved codes pass through untouched.
package cpu_oci_dct_pkg;

  localparam int SYM_W       = 2;
  localparam int MAX_ENTRIES = 15;
  localparam int BUF_W       = SYM_W * MAX_ENTRIES;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FLUSH,
    DONE
  } dct_state_e;

  localparam logic [SYM_W-1:0] SYM_NOT_TAKEN = 2'b00;
  localparam logic [SYM_W-1:0] SYM_TAKEN     = 2'b01;

endpackage

// File: rtl/cpu_oci_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module cpu_oci_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_oci_dct_unpacker.sv
// Serialises packed DCT words into a stream of 2-bit branch-outcome symbols,
// reloading back-to-back on the last symbol, and handles the end-of-test flush.
module cpu_oci_dct_unpacker
  import cpu_oci_dct_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dct_valid,
  output logic              dct_ready,
  input  logic [BUF_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_last,
  input  logic              test_ending,
  output logic              test_has_ended,
  output logic [STAT_W-1:0] word_cnt,
  output logic [STAT_W-1:0] empty_cnt,
  output logic [STAT_W-1:0] sym_cnt
);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             ended_q, ended_d;
  logic             live_q;
  logic             sym_fire;
  logic             word_fire;

  // Holds dct_ready low until the first clock after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      remain_q <= '0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      remain_q <= remain_d;
      ended_q  <= ended_d;
    end
  end

  // NOTE: every output and next-state value gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    remain_d  = remain_q;
    ended_d   = ended_q;
    dct_ready = 1'b0;
    sym_valid = 1'b0;
    sym_data  = SYM_NOT_TAKEN;
    sym_last  = 1'b0;

    case (state_q)
      IDLE: begin
        dct_ready = live_q && !test_ending;
        if (dct_valid && dct_ready) begin
          if (dct_count != '0) begin
            shift_d  = dct_buffer;
            remain_d = dct_count;
            state_d  = EMIT;
          end
        end else if (live_q && test_ending) begin
          state_d = FLUSH;
        end
      end

      EMIT: begin
        sym_valid = 1'b1;
        sym_data  = shift_q[SYM_W-1:0];
        sym_last  = (remain_q == CNT_W'(1));
        if (sym_ready) begin
          shift_d  = shift_q >> SYM_W;
          remain_d = remain_q - CNT_W'(1);
          // Last symbol leaving: a waiting word may load in the same cycle.
          if (sym_last) begin
            dct_ready = dct_valid && !test_ending;
            if (dct_ready && (dct_count != '0)) begin
              shift_d  = dct_buffer;
              remain_d = dct_count;
            end else if (test_ending) begin
              state_d = FLUSH;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      FLUSH: begin
        ended_d = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sym_fire       = sym_valid && sym_ready;
  assign word_fire      = dct_valid && dct_ready;
  assign test_has_ended = ended_q;

  cpu_oci_sat_counter #(.W(STAT_W)) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (word_fire && (dct_count != '0)),
    .count_o (word_cnt)
  );

  cpu_oci_sat_counter #(.W(STAT_W)) u_empty_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (word_fire && (dct_count == '0)),
    .count_o (empty_cnt)
  );

  cpu_oci_sat_counter #(.W(STAT_W)) u_sym_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (sym_fire),
    .count_o (sym_cnt)
  );

endmodule

// File: tb/tb_cpu_oci_dct_unpacker.sv
// Randomised and directed bench for the DCT unpacker, checked every cycle
// against a queue-of-symbols reference model.
module tb_cpu_oci_dct_unpacker;
  import cpu_oci_dct_pkg::*;

  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              dct_valid = 1'b0;
  logic              dct_ready;
  logic [BUF_W-1:0]  dct_buffer = '0;
  logic [CNT_W-1:0]  dct_count = '0;
  logic              sym_valid;
  logic              sym_ready = 1'b0;
  logic [SYM_W-1:0]  sym_data;
  logic              sym_last;
  logic              test_ending = 1'b0;
  logic              test_has_ended;
  logic [STAT_W-1:0] word_cnt;
  logic [STAT_W-1:0] empty_cnt;
  logic [STAT_W-1:0] sym_cnt;

  always #5 clk = ~clk;

  cpu_oci_dct_unpacker #(.STAT_W(STAT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .sym_data       (sym_data),
    .sym_last       (sym_last),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .word_cnt       (word_cnt),
    .empty_cnt      (empty_cnt),
    .sym_cnt        (sym_cnt)
  );

  typedef struct packed {
    logic [SYM_W-1:0] data;
    logic             last;
  } sym_t;

  // Reference model: pending symbols of the word being delivered, plus flags.
  sym_t exp_q[$];
  bit   m_live, m_flushing, m_ended, last_acc;
  int   m_words, m_empties, m_syms;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0;
  logic [BUF_W-1:0] b15;
  int   pat [6] = '{1, 0, 0, 1, 1, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << STAT_W) - 1) ? v : v + 1;
  endfunction

  function automatic logic [CNT_W-1:0] pick_count();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return '0;
    if (r == 1) return CNT_W'(15);
    return CNT_W'($urandom_range(1, 15));
  endfunction

  // One clock: compare outputs at the falling edge, then advance the model over the rising edge.
  task automatic step();
    bit busy, exp_ready, acc, sxfer;
    @(negedge clk);
    busy      = (exp_q.size() != 0);
    exp_ready = m_live && !m_flushing && !m_ended && !test_ending &&
                (!busy || (exp_q.size() == 1 && sym_ready && dct_valid));
    check("sym_valid", sym_valid, busy);
    check("dct_ready", dct_ready, exp_ready);
    check("test_has_ended", test_has_ended, m_ended);
    check("word_cnt", word_cnt, m_words);
    check("empty_cnt", empty_cnt, m_empties);
    check("sym_cnt", sym_cnt, m_syms);
    if (busy) begin
      check("sym_data", sym_data, exp_q[0].data);
      check("sym_last", sym_last, exp_q[0].last);
    end
    acc   = dct_valid && exp_ready;
    sxfer = busy && sym_ready;
    @(posedge clk);
    if (sxfer) begin
      void'(exp_q.pop_front());
      m_syms = sat_inc(m_syms);
    end
    if (acc) begin
      if (dct_count == '0) begin
        m_empties = sat_inc(m_empties);
      end else begin
        m_words = sat_inc(m_words);
        for (int i = 0; i < int'(dct_count); i++)
          exp_q.push_back('{data: SYM_W'((dct_buffer >> (SYM_W * i)) & 3), last: (i == int'(dct_count) - 1)});
      end
    end
    if (m_flushing) begin
      m_flushing = 1'b0;
      m_ended    = 1'b1;
    end else if (m_live && !m_ended && test_ending && !acc && exp_q.size() == 0) begin
      m_flushing = 1'b1;
    end
    m_live   = 1'b1;
    last_acc = acc;
    cyc++;
    #1;
  endtask

  task automatic send(input logic [BUF_W-1:0] b, input logic [CNT_W-1:0] c);
    dct_valid  = 1'b1;
    dct_buffer = b;
    dct_count  = c;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_acc) return;
    end
    check("send_timeout", last_acc, 1);
  endtask

  // Asserts reset between clock edges and checks the outputs clear immediately.
  task automatic pulse_reset();
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_data", sym_data, 0);
    check("rst_sym_last", sym_last, 0);
    check("rst_dct_ready", dct_ready, 0);
    check("rst_ended", test_has_ended, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    exp_q.delete();
    m_live = 0; m_flushing = 0; m_ended = 0;
    m_words = 0; m_empties = 0; m_syms = 0;
    dct_valid   = 1'b0;
    test_ending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    pulse_reset();
    step();

    // Basic word: 01,10,11 with one-cycle latency.
    sym_ready = 1'b1;
    send(30'h0000_0039, 4'd3);
    dct_valid = 1'b0;
    repeat (3) step();
    check("t1_word_cnt", word_cnt, 1);
    check("t1_sym_cnt", sym_cnt, 3);

    // Back-to-back words with no bubble.
    for (int i = 0; i < MAX_ENTRIES; i++) b15[SYM_W*i +: SYM_W] = SYM_TAKEN;
    send(b15, 4'd15);
    t0 = cyc;
    send(30'h0000_0002, 4'd1);
    check("t2_b2b_cycle", cyc - t0, 15);
    dct_valid = 1'b0;
    repeat (2) step();

    // Downstream stall pattern 1,0,0,1,1,1.
    send(BUF_W'($urandom), 4'd4);
    dct_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sym_ready = pat[i][0];
      step();
    end
    check("t3_drained", sym_valid, 0);

    // Empty word with all upper bits set.
    sym_ready = 1'b1;
    send('1, 4'd0);
    dct_valid = 1'b0;
    step();
    check("t4_ready", dct_ready, 1);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      if (!dct_valid && $urandom_range(0, 2) == 0) begin
        dct_valid  = 1'b1;
        dct_buffer = BUF_W'($urandom);
        dct_count  = pick_count();
      end
      sym_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc) begin
        if ($urandom_range(0, 1) == 1) begin
          dct_buffer = BUF_W'($urandom);
          dct_count  = pick_count();
        end else begin
          dct_valid = 1'b0;
        end
      end
    end
    dct_valid = 1'b0;
    sym_ready = 1'b1;
    repeat (20) step();

    // Reset in the middle of a word.
    send(BUF_W'($urandom), 4'd10);
    dct_valid = 1'b0;
    repeat (2) step();
    pulse_reset();
    repeat (5) step();

    // Flush requested mid-word.
    send(BUF_W'($urandom), 4'd5);
    repeat (2) step();
    test_ending = 1'b1;
    dct_valid   = 1'b1;
    dct_buffer  = BUF_W'($urandom);
    dct_count   = 4'd3;
    repeat (8) step();
    check("t5_ended", test_has_ended, 1);
    test_ending = 1'b0;
    repeat (3) step();
    check("t5_ended_sticky", test_has_ended, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
